// File: rtl/ravan_job_master.sv
`default_nettype none
// ============================================================================
// Module   : ravan_job_master
// Brief    : Upstream master for the RAVAN AXI-style crypto slave. Takes one
//            job at a time, walks the slave through AW/W/B/AR/R, captures
//            the result and SHA error flag, and returns them on a result
//            port. A per-phase watchdog aborts jobs stuck on a hung slave.
// Revision : 1.0  initial release
// ============================================================================
module ravan_job_master #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         job_valid,
    output logic         job_ready,
    input  logic [63:0]  job_data,
    input  logic [511:0] job_key,
    input  logic [15:0]  job_addr,

    output logic         res_valid,
    input  logic         res_ready,
    output logic [63:0]  res_data,
    output logic         res_sha_error,
    output logic         res_timeout,

    output logic         busy,
    output logic [15:0]  done_count,

    output logic [63:0]  m_data,
    output logic [511:0] m_key,
    output logic [15:0]  m_address,
    output logic         m_awvalid,
    output logic         m_wvalid,
    output logic         m_bready,
    output logic         m_arvalid,
    output logic         m_rready,
    input  logic         m_awready,
    input  logic         m_wready,
    input  logic         m_bvalid,
    input  logic         m_arready,
    input  logic         m_rvalid,
    input  logic [63:0]  m_data_out,
    input  logic         m_sha_error
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_AW      = 4'd1,
        ST_W       = 4'd2,
        ST_B       = 4'd3,
        ST_AR      = 4'd4,
        ST_R       = 4'd5,
        ST_R_FLUSH = 4'd6,
        ST_CAPTURE = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    // Watchdog fires when the counter sits at TIMEOUT-1 in a waiting phase.
    localparam logic [TO_W-1:0] c_wd_limit = TO_W'(TIMEOUT - 1);
    localparam logic            c_wd_on    = (TIMEOUT != 0);

    state_t         r_state;
    logic [TO_W-1:0] r_wd;
    logic           r_job_ready;
    logic           r_awvalid;
    logic           r_wvalid;
    logic           r_bready;
    logic           r_arvalid;
    logic           r_rready;
    logic [63:0]    r_data;
    logic [511:0]   r_key;
    logic [15:0]    r_addr;
    logic           r_res_valid;
    logic [63:0]    r_res_data;
    logic           r_res_sha;
    logic           r_res_timeout;
    logic [15:0]    r_done_count;

    state_t         w_state;
    logic [TO_W-1:0] w_wd;
    logic           w_job_ready;
    logic           w_awvalid;
    logic           w_wvalid;
    logic           w_bready;
    logic           w_arvalid;
    logic           w_rready;
    logic [63:0]    w_data;
    logic [511:0]   w_key;
    logic [15:0]    w_addr;
    logic           w_res_valid;
    logic [63:0]    w_res_data;
    logic           w_res_sha;
    logic           w_res_timeout;
    logic [15:0]    w_done_count;
    logic           w_wd_expire;
    logic           w_timeout_hit;
    logic           w_waiting;

    assign w_wd_expire = c_wd_on && (r_wd == c_wd_limit);
    assign w_waiting   = (r_state == ST_AW) || (r_state == ST_W) || (r_state == ST_B) ||
                         (r_state == ST_AR) || (r_state == ST_R);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state       = r_state;
        w_awvalid     = r_awvalid;
        w_wvalid      = r_wvalid;
        w_bready      = r_bready;
        w_arvalid     = r_arvalid;
        w_rready      = r_rready;
        w_data        = r_data;
        w_key         = r_key;
        w_addr        = r_addr;
        w_res_valid   = r_res_valid;
        w_res_data    = r_res_data;
        w_res_sha     = r_res_sha;
        w_res_timeout = r_res_timeout;
        w_done_count  = r_done_count;
        w_timeout_hit = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (job_valid && r_job_ready) begin
                    w_data    = job_data;
                    w_key     = job_key;
                    w_addr    = job_addr;
                    w_awvalid = 1'b1;
                    w_state   = ST_AW;
                end
            end
            ST_AW: begin
                if (r_awvalid && m_awready) begin
                    w_awvalid = 1'b0;
                    w_wvalid  = 1'b1;
                    w_state   = ST_W;
                end else if (w_wd_expire) begin
                    w_timeout_hit = 1'b1;
                end
            end
            ST_W: begin
                if (r_wvalid && m_wready) begin
                    w_wvalid = 1'b0;
                    w_state  = ST_B;
                end else if (w_wd_expire) begin
                    w_timeout_hit = 1'b1;
                end
            end
            ST_B: begin
                // bready only after bvalid: the slave exits its write state on bready alone.
                if (m_bvalid) begin
                    w_bready = 1'b1;
                    w_state  = ST_AR;
                end else if (w_wd_expire) begin
                    w_timeout_hit = 1'b1;
                end
            end
            ST_AR: begin
                w_bready = 1'b0;
                if (r_arvalid && m_arready) begin
                    w_arvalid = 1'b0;
                    w_state   = ST_R;
                end else if (w_wd_expire) begin
                    w_timeout_hit = 1'b1;
                end else begin
                    w_arvalid = 1'b1;
                end
            end
            ST_R: begin
                if (m_rvalid) begin
                    w_rready = 1'b1;
                    w_state  = ST_R_FLUSH;
                end else if (w_wd_expire) begin
                    w_timeout_hit = 1'b1;
                end
            end
            ST_R_FLUSH: begin
                // The slave registers data_out on the edge it samples rready.
                w_rready = 1'b0;
                w_state  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_res_data    = m_data_out;
                w_res_sha     = m_sha_error;
                w_res_timeout = 1'b0;
                w_res_valid   = 1'b1;
                w_done_count  = r_done_count + 16'd1;
                w_state       = ST_DONE;
            end
            ST_DONE: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid = 1'b0;
                    w_state     = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Watchdog abort: drop all slave handshakes and report a timed-out job.
        if (w_timeout_hit) begin
            w_awvalid     = 1'b0;
            w_wvalid      = 1'b0;
            w_bready      = 1'b0;
            w_arvalid     = 1'b0;
            w_rready      = 1'b0;
            w_res_data    = 64'd0;
            w_res_sha     = 1'b0;
            w_res_timeout = 1'b1;
            w_res_valid   = 1'b1;
            w_done_count  = r_done_count + 16'd1;
            w_state       = ST_DONE;
        end

        w_job_ready = (w_state == ST_IDLE);

        if (w_state != r_state) begin
            w_wd = '0;
        end else if (w_waiting) begin
            w_wd = r_wd + 1'b1;
        end else begin
            w_wd = '0;
        end
    end

    // State and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_wd          <= '0;
            r_job_ready   <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_data        <= 64'd0;
            r_key         <= 512'd0;
            r_addr        <= 16'd0;
            r_res_valid   <= 1'b0;
            r_res_data    <= 64'd0;
            r_res_sha     <= 1'b0;
            r_res_timeout <= 1'b0;
            r_done_count  <= 16'd0;
        end else begin
            r_state       <= w_state;
            r_wd          <= w_wd;
            r_job_ready   <= w_job_ready;
            r_awvalid     <= w_awvalid;
            r_wvalid      <= w_wvalid;
            r_bready      <= w_bready;
            r_arvalid     <= w_arvalid;
            r_rready      <= w_rready;
            r_data        <= w_data;
            r_key         <= w_key;
            r_addr        <= w_addr;
            r_res_valid   <= w_res_valid;
            r_res_data    <= w_res_data;
            r_res_sha     <= w_res_sha;
            r_res_timeout <= w_res_timeout;
            r_done_count  <= w_done_count;
        end
    end

    assign job_ready     = r_job_ready;
    assign busy          = (r_state != ST_IDLE);
    assign done_count    = r_done_count;
    assign m_data        = r_data;
    assign m_key         = r_key;
    assign m_address     = r_addr;
    assign m_awvalid     = r_awvalid;
    assign m_wvalid      = r_wvalid;
    assign m_bready      = r_bready;
    assign m_arvalid     = r_arvalid;
    assign m_rready      = r_rready;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign res_sha_error = r_res_sha;
    assign res_timeout   = r_res_timeout;

endmodule
`default_nettype wire

// File: doc/ravan_job_master.md
Name: ravan_job_master

Overview:
- Upstream master for the RAVAN AXI-style crypto slave wrapper.
- Accepts one encryption job at a time (64-bit data, 512-bit key, 16-bit address) over a valid/ready port.
- Sequences the slave's AW → W → B → AR → R handshakes and captures the 64-bit result and SHA error flag.
- Returns the result on a valid/ready result port, with a per-phase timeout watchdog so a hung slave cannot stall the pipeline forever.

Parameters:
- TIMEOUT, 64: max cycles spent waiting in any one handshake phase; 0 disables the watchdog.
- TO_W, 8: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  block can accept a job
- job_data  in  64  plaintext word
- job_key  in  512  key
- job_addr  in  16  target address
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  64  captured slave output
- res_sha_error  out  1  captured slave SHA error
- res_timeout  out  1  job aborted by watchdog
- busy  out  1  state != IDLE
- done_count  out  16  completed jobs, including timeouts; wraps
- m_data  out  64  data to slave
- m_key  out  512  key to slave
- m_address  out  16  address to slave
- m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready  out  1 each  slave handshake drives
- m_awready, m_wready, m_bvalid, m_arready, m_rvalid  in  1 each  slave handshake responses
- m_data_out  in  64  slave result
- m_sha_error  in  1  slave SHA error

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low (clk, rst).
  - On reset, all outputs are 0, state = IDLE, watchdog = 0, done_count = 0.
  - Reset mid-job drops every m_* handshake within the reset and discards the job.
- job_ready = 1 only in IDLE (registered). Accept on job_valid && job_ready: latch data/key/addr into m_data/m_key/m_address.
  - These hold stable until the next accept; the slave samples them during the W handshake.
- States: IDLE, AW, W, B, AR, R, R_FLUSH, CAPTURE, DONE.
- Transitions:
  - IDLE: on accept, m_awvalid <= 1, go to AW.
  - AW: on m_awvalid && m_awready, m_awvalid <= 0, m_wvalid <= 1, go to W.
  - W: on m_wready, m_wvalid <= 0, go to B.
  - B: on m_bvalid, m_bready <= 1 for exactly one cycle, go to AR.
    - m_bready must never be high before m_bvalid is seen, because the slave leaves its write state on bready alone.
  - AR: m_bready <= 0 and m_arvalid <= 1 on entry; on m_arready, m_arvalid <= 0, go to R.
  - R: on m_rvalid, m_rready <= 1 for exactly one cycle, go to R_FLUSH.
    - m_rready is never asserted without m_rvalid.
  - R_FLUSH: m_rready <= 0. This cycle exists because the slave registers data_out on the same edge it samples rready.
  - CAPTURE: res_data <= m_data_out, res_sha_error <= m_sha_error, res_timeout <= 0, res_valid <= 1, done_count++, go to DONE.
    - Capture therefore happens two edges after m_rready rises.
  - DONE: hold res_* until res_valid && res_ready, then res_valid <= 0 and go to IDLE. No new job is accepted while in DONE.
- Latency: with a zero-wait slave, minimum job_accept → res_valid is about 14 cycles, including the slave's 3-cycle internal wait. No exact figure is mandated; only the ordering rules apply.
- Watchdog:
  - Counter clears on every state change and increments each cycle in AW/W/B/AR/R.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no qualifying handshake:
    - clear all m_* valids/readies;
    - res_data <= 0, res_sha_error <= 0, res_timeout <= 1, res_valid <= 1;
    - increment done_count and go to DONE.
  - A handshake in the same cycle as expiry wins; no timeout is raised.
- done_count wraps 0xFFFF → 0.
- Handshake-pulse ordering: at most one of m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready is high in any cycle.

Test Plan:
- Nominal job:
  - Stimulus: data 0x0123456789ABCDEF, key {8{64'hA5A5...}}, addr 0x0010; slave model returns 0xDEADBEEFCAFEF00D, sha_error 0.
  - Required response: one res_valid with res_data = 0xDEADBEEFCAFEF00D, res_timeout = 0, done_count = 1; handshakes strictly in AW, W, B, AR, R order.
- Back-pressure:
  - Stimulus: res_ready held low 20 cycles after res_valid.
  - Required response: res_* stable, job_ready = 0 throughout; after release, IDLE and job_ready = 1 next cycle.
- SHA error propagation:
  - Stimulus: slave m_sha_error = 1 at the R phase.
  - Required response: res_sha_error = 1, res_data equals the slave value.
- Timeout:
  - Stimulus: TIMEOUT = 8, slave never asserts m_arready.
  - Required response: after 8 AR cycles, m_arvalid = 0, res_valid = 1, res_timeout = 1, res_data = 0; the next job then completes normally.
- Reset mid-job:
  - Stimulus: deassert rst during the W phase.
  - Required response: all outputs 0 asynchronously; after release, IDLE, job_ready = 1, done_count = 0.
- Back-to-back jobs and counter wrap:
  - Stimulus: 3 back-to-back jobs with job_valid held high; separately, preload done_count to 0xFFFF via forced state.
  - Required response: 3 results returned in order with distinct data; the next completion wraps done_count to 0.
